// File: rtl/mcs4_axi_pkg.sv
// Shared AXI4 constants, FSM state types and burst legality helper for the
// MCS4 AXI4 memory slave.
package mcs4_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Bursts that are rejected outright: only full-word beats are supported and
  // WRAP needs a power-of-two beat count.
  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != SIZE_WORD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/mcs4_axi_addr_gen.sv
// Next-beat address for one AXI burst step: FIXED holds, INCR and the reserved
// encoding step by one word, WRAP steps within a (len+1)-word aligned window.
module mcs4_axi_addr_gen
  import mcs4_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  // For legal wrap lengths (2^n - 1) this is exactly the window byte mask.
  assign wrap_mask = ADDR_WIDTH'({len, 2'b11});
  assign incr_addr = addr + ADDR_WIDTH'(4);

  always_comb begin
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/mcs4_axi4_mem_slave.sv
// AXI4 full slave backed by a word-addressed RAM with independent write and
// read burst engines.
//   state  | meaning
//   W_IDLE | waiting for AW handshake (awready=1)
//   W_DATA | accepting write beats (wready=1)
//   W_RESP | presenting write response (bvalid=1)
//   R_IDLE | waiting for AR handshake (arready=1)
//   R_DATA | presenting a registered read beat (rvalid=1)
module mcs4_axi4_mem_slave
  import mcs4_axi_pkg::*;
#(
  parameter int C_S00_AXI_ID_WIDTH   = 1,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awlock,
  input  logic [3:0]                        s00_axi_awcache,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic [3:0]                        s00_axi_awqos,
  input  logic [3:0]                        s00_axi_awregion,
  input  logic                              s00_axi_awuser,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wuser,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arlock,
  input  logic [3:0]                        s00_axi_arcache,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic [3:0]                        s00_axi_arqos,
  input  logic [3:0]                        s00_axi_arregion,
  input  logic                              s00_axi_aruser,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);

  localparam int AW    = C_S00_AXI_ADDR_WIDTH;
  localparam int DW    = C_S00_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** (AW - 2);

  logic [DW-1:0] mem [DEPTH];

  w_state_t      w_state, w_state_nxt;
  logic [AW-1:0] w_addr, w_addr_nxt;
  logic [7:0]    w_len, w_cnt;
  logic [1:0]    w_burst;
  logic          w_nowrite;
  logic          aw_hs, w_hs, w_cnt_end, w_mismatch, w_final;

  r_state_t      r_state, r_state_nxt;
  logic [AW-1:0] r_addr, r_gen_addr, r_gen_nxt;
  logic [7:0]    r_len, r_cnt, r_gen_len;
  logic [1:0]    r_burst, r_gen_burst;
  logic          r_err, ar_err, ar_hs, r_hs;
  logic [AW-3:0] rd_idx;

  logic unused_sideband;
  assign unused_sideband = ^{s00_axi_awlock, s00_axi_awcache, s00_axi_awprot, s00_axi_awqos,
                             s00_axi_awregion, s00_axi_awuser, s00_axi_wuser,
                             s00_axi_arlock, s00_axi_arcache, s00_axi_arprot, s00_axi_arqos,
                             s00_axi_arregion, s00_axi_aruser};

  // ---------------- write channel ----------------
  assign aw_hs      = s00_axi_awvalid & s00_axi_awready;
  assign w_hs       = s00_axi_wvalid & s00_axi_wready;
  assign w_cnt_end  = (w_cnt == w_len);
  assign w_mismatch = (s00_axi_wlast != w_cnt_end);
  assign w_final    = s00_axi_wlast | w_cnt_end;

  mcs4_axi_addr_gen #(.ADDR_WIDTH(AW)) u_w_addr_gen (
    .addr      (w_addr),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_addr_nxt)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) w_state <= W_IDLE;
    else                  w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = w_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s00_axi_awready = s00_axi_aresetn;
        if (s00_axi_awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_nowrite     <= 1'b0;
      s00_axi_bid   <= '0;
      s00_axi_bresp <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr      <= s00_axi_awaddr;
      w_len       <= s00_axi_awlen;
      w_cnt       <= '0;
      w_burst     <= s00_axi_awburst;
      w_nowrite   <= burst_err(s00_axi_awsize, s00_axi_awburst, s00_axi_awlen);
      s00_axi_bid <= s00_axi_awid;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_cnt  <= w_cnt + 8'd1;
      // A wlast/count disagreement can only surface on the terminating beat.
      if (w_final) s00_axi_bresp <= (w_nowrite || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Storage is deliberately not reset so data survives an aborted burst.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_hs && !w_nowrite) begin
      for (int b = 0; b < NB; b++) begin
        if (s00_axi_wstrb[b]) mem[w_addr[AW-1:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign r_hs   = s00_axi_rvalid & s00_axi_rready;
  assign ar_err = burst_err(s00_axi_arsize, s00_axi_arburst, s00_axi_arlen);

  // In idle the generator works on the incoming request so beat 0 and the
  // address of beat 1 are both ready at the AR handshake edge.
  assign r_gen_addr  = (r_state == R_IDLE) ? s00_axi_araddr  : r_addr;
  assign r_gen_len   = (r_state == R_IDLE) ? s00_axi_arlen   : r_len;
  assign r_gen_burst = (r_state == R_IDLE) ? s00_axi_arburst : r_burst;
  assign rd_idx      = r_gen_addr[AW-1:2];

  mcs4_axi_addr_gen #(.ADDR_WIDTH(AW)) u_r_addr_gen (
    .addr      (r_gen_addr),
    .len       (r_gen_len),
    .burst     (r_gen_burst),
    .next_addr (r_gen_nxt)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= R_IDLE;
    else                  r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt     = r_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s00_axi_arready = s00_axi_aresetn;
        if (s00_axi_arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready && s00_axi_rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Reading mem with non-blocking semantics gives pre-write data on a
  // same-edge write to the same word.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
      s00_axi_rid   <= '0;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
      s00_axi_rlast <= 1'b0;
    end else if (ar_hs) begin
      r_addr        <= r_gen_nxt;
      r_len         <= s00_axi_arlen;
      r_cnt         <= '0;
      r_burst       <= s00_axi_arburst;
      r_err         <= ar_err;
      s00_axi_rid   <= s00_axi_arid;
      s00_axi_rdata <= ar_err ? '0 : mem[rd_idx];
      s00_axi_rresp <= ar_err ? RESP_SLVERR : RESP_OKAY;
      s00_axi_rlast <= (s00_axi_arlen == 8'd0);
    end else if (r_hs && !s00_axi_rlast) begin
      r_addr        <= r_gen_nxt;
      r_cnt         <= r_cnt + 8'd1;
      s00_axi_rdata <= r_err ? '0 : mem[rd_idx];
      s00_axi_rlast <= ((r_cnt + 8'd1) == r_len);
    end
  end

endmodule

// File: doc/mcs4_axi4_mem_slave.md
MCS4_AXI4_MEM_SLAVE -- requirements
Module: mcs4_axi4_mem_slave

Interface
REQ-001 SHALL have parameter C_S00_AXI_ID_WIDTH, default 1, meaning AXI ID width.
REQ-002 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 8, meaning byte-address width; memory depth is 2^(ADDR_WIDTH-2) words.
REQ-004 s00_axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 s00_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel.
REQ-007 s00_axi_awvalid in 1, s00_axi_awready out 1  write address handshake.
REQ-008 s00_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data channel; s00_axi_wready out 1.
REQ-009 s00_axi_bid/bresp/bvalid  out  ID/2/1  write response; s00_axi_bready in 1.
REQ-010 s00_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID/ADDR/8/3/2/1  read address channel; s00_axi_arready out 1.
REQ-011 s00_axi_rid/rdata/rresp/rlast/rvalid  out  ID/32/2/1/1  read data channel; s00_axi_rready in 1.
REQ-012 Lock, cache, prot, qos, region and user inputs SHALL be accepted and ignored.

Function
REQ-013 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE.
REQ-014 On AW handshake, SHALL latch id/addr/len/size/burst, clear beat count and go to W_DATA next cycle.
REQ-015 In W_DATA, wready=1; each W handshake SHALL write wdata to mem[addr[ADDR-1:2]] byte-wise per wstrb, then advance address and count.
REQ-016 SHALL go to W_RESP on the beat where wlast=1 or count==len, whichever is first.
REQ-017 In W_RESP: bvalid=1, bid=latched id; bvalid held until bready; handshake SHALL return to W_IDLE (awready=1 next cycle).
REQ-018 bresp SHALL be OKAY(00), except SLVERR(10) if wlast mismatches count==len, awsize!=2, or burst is WRAP with len not in {1,3,7,15}; in the size and WRAP-len error cases, no memory writes occur.
REQ-019 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE.
REQ-020 AR handshake at cycle N SHALL produce rvalid=1 at N+1 with rdata=mem[araddr]; rid=latched arid.
REQ-021 rdata, rlast and rresp SHALL be registered and stable while rvalid=1 and rready=0.
REQ-022 On each R handshake, SHALL load the next beat's data in the same edge; after the beat with count==len (rlast=1), SHALL go to R_IDLE.
REQ-023 rresp SHALL follow the same SLVERR rules as REQ-018, with rdata=0 for error bursts.
REQ-024 Next address: FIXED (00) unchanged; INCR (01) +4; WRAP (10) +4, wrapping within a (len+1)*4-aligned window; reserved (11) treated as INCR.
REQ-025 Addresses beyond memory depth SHALL alias modulo depth; no DECERR.
REQ-026 Read and write FSMs SHALL run independently and concurrently.
REQ-027 A same-cycle write and read-data load to the same word SHALL return the old (pre-write) data.

Reset
REQ-028 While aresetn=0: awready, wready, bvalid, arready, rvalid, rlast=0; bresp, rresp, bid, rid, rdata=0; FSMs in W_IDLE/R_IDLE.
REQ-029 awready and arready SHALL be 1 in the first clock after reset release.
REQ-030 Reset mid-burst SHALL abort the burst, with no B/R response issued; words already written are retained; memory contents are not reset.

Structure
REQ-031 Package mcs4_axi_pkg SHALL hold burst-type and resp-code constants and the write/read FSM state enums.
REQ-032 Next-address logic SHALL be one sub-module, mcs4_axi_addr_gen (addr, len, burst in; next addr out), instantiated once per channel.

Verification
REQ-033 INCR write len=7, size=2, addr 0x00, data 1..8, then matching read -> bresp=00; rdata 1..8; rlast only on beat 8; rid=bid=awid.
REQ-034 Write 0xFFFFFFFF to 0x10, then 0x000000AA with wstrb=0001; read 0x10 -> 0xFFFFFFAA.
REQ-035 WRAP write len=3 at 0x08 with data A,B,C,D; INCR read len=3 at 0x00 -> C,D,A,B.
REQ-036 Read len=7 with rready held low 3 cycles mid-burst -> rdata/rlast unchanged during the stall; all 8 beats correct.
REQ-037 Write len=7 with wlast on beat 4 -> bresp=10 after beat 4; a concurrent read burst completes unaffected.
REQ-038 Assert aresetn=0 at beat 3 of a write burst -> all outputs 0 during reset; awready=1 the cycle after release; beats 1-3 readable.
